// File: rtl/regfile_writeback_arbiter.sv
// Write-port master for the 32x32 register file: merges pipeline writebacks with
// in-order long-latency results (via a small FIFO) and tracks pending destinations.
module regfile_writeback_arbiter #(
    parameter int DW         = 32,
    parameter int QDEPTH     = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        pipe_valid,
    input  logic [4:0]                  pipe_sel,
    input  logic [DW-1:0]               pipe_dat,
    output logic                        pipe_ready,
    input  logic                        lu_valid,
    input  logic [4:0]                  lu_sel,
    input  logic [DW-1:0]               lu_dat,
    output logic                        lu_ready,
    input  logic                        issue_en,
    input  logic [4:0]                  issue_sel,
    output logic [31:0]                 pending,
    output logic [$clog2(QDEPTH):0]     q_count,
    output logic                        rf_WEN,
    output logic [4:0]                  rf_wsel,
    output logic [DW-1:0]               rf_wdat
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]    r_q_sel [QDEPTH];
    logic [DW-1:0] r_q_dat [QDEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic [31:0]   r_pending;
    logic          r_wen;
    logic [4:0]    r_wsel;
    logic [DW-1:0] r_wdat;

    logic          w_nonempty;
    logic          w_force;
    logic          w_pop;
    logic          w_push;
    logic [4:0]    w_head_sel;
    logic [DW-1:0] w_head_dat;
    logic [31:0]   w_pending_next;

    assign w_nonempty = (r_count != '0);
    assign w_force    = w_nonempty && (r_starve == SW'(STARVE_MAX));
    assign w_pop      = w_force || (w_nonempty && !pipe_valid);
    assign lu_ready   = (r_count < CW'(QDEPTH));
    // Results for r0 are consumed here and never occupy a FIFO slot.
    assign w_push     = lu_valid && lu_ready && (lu_sel != 5'd0);
    assign w_head_sel = r_q_sel[r_rptr];
    assign w_head_dat = r_q_dat[r_rptr];
    assign pipe_ready = !w_force;

    // Issue set takes priority over a same-cycle FIFO retire of the same register.
    assign w_pending_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_sb
            assign w_pending_next[gi] = (issue_en && (issue_sel == 5'(gi)))
                                      || (r_pending[gi] && !(w_pop && (w_head_sel == 5'(gi))));
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_q_sel[r_wptr] <= lu_sel;
            r_q_dat[r_wptr] <= lu_dat;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_starve  <= '0;
            r_pending <= '0;
            r_wen     <= 1'b0;
            r_wsel    <= '0;
            r_wdat    <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (!w_nonempty || w_pop)
                r_starve <= '0;
            else if (r_starve != SW'(STARVE_MAX))
                r_starve <= r_starve + SW'(1);
            r_pending <= w_pending_next;
            if (w_pop) begin
                r_wen  <= 1'b1;
                r_wsel <= w_head_sel;
                r_wdat <= w_head_dat;
            end else if (pipe_valid) begin
                r_wen  <= (pipe_sel != 5'd0);
                r_wsel <= pipe_sel;
                r_wdat <= pipe_dat;
            end else begin
                r_wen  <= 1'b0;
            end
        end
    end

    assign pending = r_pending;
    assign q_count = r_count;
    assign rf_WEN  = r_wen;
    assign rf_wsel = r_wsel;
    assign rf_wdat = r_wdat;
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Randomized and directed checks of regfile_writeback_arbiter against a queue-based model.
module tb_regfile_writeback_arbiter;
    localparam int DW = 32;
    localparam int QDEPTH = 4;
    localparam int STARVE_MAX = 8;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        pipe_valid = 1'b0;
    logic [4:0]  pipe_sel = '0;
    logic [31:0] pipe_dat = '0;
    logic        pipe_ready;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_sel = '0;
    logic [31:0] lu_dat = '0;
    logic        lu_ready;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_sel = '0;
    logic [31:0] pending;
    logic [2:0]  q_count;
    logic        rf_WEN;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;

    int total = 0;
    int bad = 0;

    regfile_writeback_arbiter #(.DW(DW), .QDEPTH(QDEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK(CLK), .nRST(nRST),
        .pipe_valid(pipe_valid), .pipe_sel(pipe_sel), .pipe_dat(pipe_dat), .pipe_ready(pipe_ready),
        .lu_valid(lu_valid), .lu_sel(lu_sel), .lu_dat(lu_dat), .lu_ready(lu_ready),
        .issue_en(issue_en), .issue_sel(issue_sel), .pending(pending), .q_count(q_count),
        .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] dat;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pend;
    int          m_starve;
    logic        m_wen;
    logic [4:0]  m_wsel;
    logic [31:0] m_wdat;

    function automatic void model_reset();
        mq.delete();
        m_pend = '0;
        m_starve = 0;
        m_wen = 1'b0;
        m_wsel = '0;
        m_wdat = '0;
    endfunction

    function automatic logic model_pipe_ready();
        return !(mq.size() != 0 && m_starve == STARVE_MAX);
    endfunction

    task automatic set_in(input logic pv, input logic [4:0] ps, input logic [31:0] pd,
                          input logic lv, input logic [4:0] lsel, input logic [31:0] ldat,
                          input logic ie, input logic [4:0] isel);
        pipe_valid = pv; pipe_sel = ps; pipe_dat = pd;
        lu_valid = lv; lu_sel = lsel; lu_dat = ldat;
        issue_en = ie; issue_sel = isel;
        #1;
    endtask

    task automatic set_idle();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    // Advance the model by one clock using the current inputs, then let the DUT clock.
    task automatic tick();
        logic ne, frc, pop, push;
        ent_t h;
        ne   = (mq.size() != 0);
        frc  = ne && (m_starve == STARVE_MAX);
        pop  = frc || (ne && !pipe_valid);
        push = lu_valid && (mq.size() < QDEPTH) && (lu_sel != 5'd0);
        if (pop) begin
            h = mq.pop_front();
            m_wen = 1'b1; m_wsel = h.sel; m_wdat = h.dat;
            m_pend[h.sel] = 1'b0;
        end else if (pipe_valid) begin
            m_wen = (pipe_sel != 5'd0); m_wsel = pipe_sel; m_wdat = pipe_dat;
        end else begin
            m_wen = 1'b0;
        end
        if (issue_en && issue_sel != 5'd0) m_pend[issue_sel] = 1'b1;
        if (push) mq.push_back('{sel: lu_sel, dat: lu_dat});
        if (!ne || pop) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve++;
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && mq.size() != 0; i++) begin
            set_idle();
            tick();
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        set_in(1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd4, 32'h1, 1'b1, 5'd6);
        repeat (3) @(posedge CLK);
        #1;
        model_reset();
        total++; if (rf_WEN !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b want=0", rf_WEN); end
        total++; if (rf_wsel !== 5'd0 || rf_wdat !== 32'd0) begin bad++; $display("FAIL reset_wsel_wdat got=%0d/%h want=0/0", rf_wsel, rf_wdat); end
        total++; if (pending !== 32'd0) begin bad++; $display("FAIL reset_pending got=%h want=0", pending); end
        total++; if (q_count !== 3'd0) begin bad++; $display("FAIL reset_qcount got=%0d want=0", q_count); end
        total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL reset_lu_ready got=%b want=1", lu_ready); end
        set_idle();
        nRST = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_pipe_write();
        set_in(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        total++; if (pipe_ready !== 1'b1) begin bad++; $display("FAIL pipe_ready got=%b want=1", pipe_ready); end
        tick();
        total++; if (rf_WEN !== 1'b1 || rf_wsel !== 5'd5 || rf_wdat !== 32'hDEADBEEF)
            begin bad++; $display("FAIL pipe_write got=%b/%0d/%h want=1/5/deadbeef", rf_WEN, rf_wsel, rf_wdat); end
        $display("pipe write: r%0d <= %h", rf_wsel, rf_wdat);
        set_idle();
        tick();
        total++; if (rf_WEN !== 1'b0) begin bad++; $display("FAIL pipe_write_single got=%b want=0", rf_WEN); end
    endtask

    task automatic test_lu_pending();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        tick();
        total++; if (pending[7] !== 1'b1) begin bad++; $display("FAIL lu_pend_set got=%b want=1", pending[7]); end
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0);
        tick();
        total++; if (q_count !== 3'd1 || pending[7] !== 1'b1 || rf_WEN !== 1'b0)
            begin bad++; $display("FAIL lu_queued got=q%0d/p%b/w%b want=q1/p1/w0", q_count, pending[7], rf_WEN); end
        set_idle();
        tick();
        total++; if (rf_WEN !== 1'b1 || rf_wsel !== 5'd7 || rf_wdat !== 32'h1234)
            begin bad++; $display("FAIL lu_write got=%b/%0d/%h want=1/7/1234", rf_WEN, rf_wsel, rf_wdat); end
        total++; if (pending[7] !== 1'b0 || q_count !== 3'd0)
            begin bad++; $display("FAIL lu_retire got=p%b/q%0d want=p0/q0", pending[7], q_count); end
        $display("lu write: r%0d <= %h", rf_wsel, rf_wdat);
        set_idle();
        tick();
    endtask

    task automatic test_reg0();
        logic [31:0] pend_before;
        pend_before = pending;
        set_in(1'b1, 5'd0, $urandom, 1'b1, 5'd0, $urandom, 1'b1, 5'd0);
        total++; if (pipe_ready !== 1'b1 || lu_ready !== 1'b1)
            begin bad++; $display("FAIL reg0_accept got=%b/%b want=1/1", pipe_ready, lu_ready); end
        tick();
        total++; if (rf_WEN !== 1'b0 || q_count !== 3'd0)
            begin bad++; $display("FAIL reg0_dropped got=w%b/q%0d want=w0/q0", rf_WEN, q_count); end
        total++; if (pending !== pend_before)
            begin bad++; $display("FAIL reg0_pending got=%h want=%h", pending, pend_before); end
        $display("reg0: pipe and lu writes to r0 dropped");
        set_idle();
        tick();
    endtask

    task automatic test_fifo_starve();
        logic [4:0]  exp_sel [4];
        logic [31:0] exp_dat [4];
        int k = 0;
        int first_force = 0;
        drain();
        for (int i = 0; i < 4; i++) begin
            exp_sel[i] = 5'(17 + i);
            exp_dat[i] = $urandom;
        end
        for (int i = 1; i <= 70 && k < 4; i++) begin
            if (i <= 4)
                set_in(1'b1, 5'($urandom_range(1, 16)), $urandom, 1'b1, exp_sel[i-1], exp_dat[i-1], 1'b0, 5'd0);
            else
                set_in(1'b1, 5'($urandom_range(1, 16)), $urandom, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
            if (i == 5) begin
                total++; if (q_count !== 3'd4 || lu_ready !== 1'b0)
                    begin bad++; $display("FAIL fifo_full got=q%0d/r%b want=q4/r0", q_count, lu_ready); end
            end
            total++; if (pipe_ready !== model_pipe_ready())
                begin bad++; $display("FAIL starve_pipe_ready cyc=%0d got=%b want=%b", i, pipe_ready, model_pipe_ready()); end
            if (!pipe_ready) begin
                if (first_force == 0) begin
                    first_force = i;
                    total++; if (lu_ready !== 1'b0)
                        begin bad++; $display("FAIL full_pop_lu_ready got=%b want=0", lu_ready); end
                end
                tick();
                total++; if (rf_WEN !== 1'b1 || rf_wsel !== exp_sel[k] || rf_wdat !== exp_dat[k])
                    begin bad++; $display("FAIL force_order k=%0d got=%b/%0d/%h want=1/%0d/%h", k, rf_WEN, rf_wsel, rf_wdat, exp_sel[k], exp_dat[k]); end
                $display("forced write: r%0d <= %h", rf_wsel, rf_wdat);
                k++;
            end else begin
                tick();
            end
        end
        total++; if (first_force !== 2 + STARVE_MAX)
            begin bad++; $display("FAIL force_timing got=%0d want=%0d", first_force, 2 + STARVE_MAX); end
        total++; if (k !== 4)
            begin bad++; $display("FAIL force_drain got=%0d want=4", k); end
        set_idle();
        tick();
    endtask

    task automatic test_random();
        logic       hold = 1'b0;
        logic [4:0] ps = '0;
        logic [31:0] pd = '0;
        logic pv;
        for (int c = 0; c < 300; c++) begin
            if (hold) pv = 1'b1;
            else begin
                pv = ($urandom_range(0, 99) < 60);
                ps = 5'($urandom_range(0, 31));
                pd = $urandom;
            end
            set_in(pv, ps, pd, ($urandom_range(0, 99) < 40), 5'($urandom_range(0, 31)), $urandom,
                   ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 31)));
            total++; if (pipe_ready !== model_pipe_ready() || lu_ready !== (mq.size() < QDEPTH))
                begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b/%b want=%b/%b", c, pipe_ready, lu_ready, model_pipe_ready(), mq.size() < QDEPTH); end
            hold = pv && !pipe_ready;
            tick();
            total++; if (rf_WEN !== m_wen || (m_wen && (rf_wsel !== m_wsel || rf_wdat !== m_wdat)))
                begin bad++; $display("FAIL rnd_write cyc=%0d got=%b/%0d/%h want=%b/%0d/%h", c, rf_WEN, rf_wsel, rf_wdat, m_wen, m_wsel, m_wdat); end
            total++; if (pending !== m_pend || q_count !== 3'(mq.size()))
                begin bad++; $display("FAIL rnd_state cyc=%0d got=%h/q%0d want=%h/q%0d", c, pending, q_count, m_pend, mq.size()); end
            if (rf_WEN) $display("rnd cyc %0d: write r%0d <= %h", c, rf_wsel, rf_wdat);
        end
        set_idle();
    endtask

    task automatic test_async_reset();
        drain();
        for (int i = 9; i <= 11; i++) begin
            set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i));
            tick();
        end
        for (int i = 9; i <= 12; i++) begin
            set_in(1'b1, 5'd1, $urandom, 1'b1, 5'(i), $urandom, 1'b0, 5'd0);
            tick();
        end
        set_idle();
        tick();
        total++; if (q_count !== 3'd3 || pending === 32'd0 || rf_WEN !== 1'b1)
            begin bad++; $display("FAIL mid_drain got=q%0d/p%h/w%b want=q3/p!=0/w1", q_count, pending, rf_WEN); end
        #2;
        nRST = 1'b0;
        #1;
        model_reset();
        total++; if (rf_WEN !== 1'b0 || pending !== 32'd0 || q_count !== 3'd0)
            begin bad++; $display("FAIL async_clear got=w%b/p%h/q%0d want=w0/p0/q0", rf_WEN, pending, q_count); end
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_idle();
            tick();
            total++; if (rf_WEN !== 1'b0 || q_count !== 3'd0)
                begin bad++; $display("FAIL post_reset cyc=%0d got=w%b/q%0d want=w0/q0", i, rf_WEN, q_count); end
        end
        $display("async reset: queue and scoreboard discarded");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_pipe_write();
        test_lu_pending();
        test_reg0();
        test_fifo_starve();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end
endmodule
